// File: rtl/inst_queue_ctrl.sv
// Instruction queue between fetcher and decoder: circular FIFO, JALR fetch gating, misprediction flush.
// Optional same-cycle fetch-to-decode bypass on an empty queue is enabled by defining QUEUE_BYPASS_EN.
module inst_queue_ctrl #(
  parameter int DEPTH_BIT = 3
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 if_valid,
  input  logic [31:0]          if_inst,
  input  logic [31:0]          if_addr,
  output logic                 if_ready,
  output logic                 start_decode,
  output logic [31:0]          dec_inst,
  output logic [31:0]          dec_inst_addr,
  input  logic                 issue_signal,
  input  logic                 wrong_predicted,
  output logic [DEPTH_BIT:0]   q_count
);

  // state     | meaning
  // RUN       | normal operation, fetch accepted while not full
  // WAIT_JALR | un-issued JALR buffered as last entry, fetch blocked
  typedef enum logic {RUN, WAIT_JALR} state_t;

  localparam int DEPTH = 1 << DEPTH_BIT;
  localparam logic [DEPTH_BIT:0] FULL_CNT = {1'b1, {DEPTH_BIT{1'b0}}};
  localparam logic [6:0] OP_JALR = 7'b1100111;

  state_t                 state_q, state_d;
  logic [DEPTH_BIT-1:0]   head_q, head_d, tail_q, tail_d;
  logic [DEPTH_BIT:0]     count_q, count_d;
  logic [31:0]            inst_mem [DEPTH];
  logic [31:0]            addr_mem [DEPTH];

  logic empty, full, active, byp, byp_take, push, pop;
  logic [31:0] head_inst, head_addr;

  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign head_inst = inst_mem[head_q];
  assign head_addr = addr_mem[head_q];
  // Reset is folded in so handshakes are quiet while rst_in is held low.
  assign active    = rst_in && rdy_in && !wrong_predicted;

`ifdef QUEUE_BYPASS_EN
  assign byp = active && empty && (state_q == RUN) && if_valid;
`else
  assign byp = 1'b0;
`endif

  assign if_ready     = active && (state_q == RUN) && !full;
  assign start_decode = active && (!empty || byp);
  assign byp_take     = byp && issue_signal;
  assign push         = if_valid && if_ready && !byp_take;
  assign pop          = issue_signal && start_decode && !empty;
  assign q_count      = count_q;

  always_comb begin
    dec_inst      = '0;
    dec_inst_addr = '0;
    if (byp) begin
      dec_inst      = if_inst;
      dec_inst_addr = if_addr;
    end else if (!empty) begin
      dec_inst      = head_inst;
      dec_inst_addr = head_addr;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rdy_in && wrong_predicted) begin
      state_d = RUN;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (pop && head_inst[6:0] == OP_JALR) state_d = RUN;
      if (push && if_inst[6:0] == OP_JALR)  state_d = WAIT_JALR;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= RUN;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      inst_mem[tail_q] <= if_inst;
      addr_mem[tail_q] <= if_addr;
    end
  end

endmodule
